fetch_stage: RTL and testbench

- Instruction fetch stage: holds the program counter, owns the instruction memory and produces the 64-bit IF_ID pipeline register consumed by the decode stage.
- Supports stall from downstream, branch redirect from execute, and a sticky halt on the HLT opcode.
- Inserts NOP bubbles on redirect and after halt.
- Instruction memory is loaded through a synchronous write port.

---
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, instruction memory and the IF_ID register.
// Handles stall, branch redirect (bubble insertion) and a sticky halt on HLT.
module fetch_stage #(
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter logic [31:0] NOP_WORD   = 32'h38000000,
  parameter logic [5:0]  HLT_OPCODE = 6'b001101
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [31:0]       imem_wdata,
  output logic [63:0]       IF_ID,
  output logic              if_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  logic [31:0] imem_q [2**ADDR_W];
  state_t      state_q;
  logic [31:0] pc_q;
  logic [63:0] ifid_q;
  logic        valid_q;
  logic        halted_q;
  logic [31:0] count_q;

  logic [31:0] instr_d;
  logic [31:0] pc_inc_d;
  logic        is_hlt_d;

  // Asynchronous read against the pre-edge array gives old-data on a same-index write.
  assign instr_d  = imem_q[pc_q[ADDR_W-1:0]];
  assign pc_inc_d = pc_q + 32'd1;
  assign is_hlt_d = (instr_d[31:26] == HLT_OPCODE);

  always_ff @(posedge clock) begin
    if (imem_we) begin
      imem_q[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      ifid_q   <= {32'h0, NOP_WORD};
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= 32'h0;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            pc_q    <= branch_target;
            ifid_q  <= {pc_q, NOP_WORD};
            valid_q <= 1'b0;
          end else if (!stall) begin
            ifid_q  <= {pc_q, instr_d};
            valid_q <= 1'b1;
            count_q <= count_q + 32'd1;
            // HLT is issued but the PC parks on it.
            if (is_hlt_d) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_inc_d;
            end
          end
        end
        HALTED: begin
          if (branch_taken) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            pc_q     <= branch_target;
            ifid_q   <= {pc_q, NOP_WORD};
            valid_q  <= 1'b0;
          end else if (!stall) begin
            ifid_q  <= {pc_q, NOP_WORD};
            valid_q <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign IF_ID       = ifid_q;
  assign if_valid    = valid_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: vector table plus hand-written
// sequences for mid-run reset and same-edge imem write.
module tb_fetch_stage;

  localparam int ADDR_W = 8;
  localparam logic [31:0] NOP = 32'h38000000;

  logic              clock = 1'b0;
  logic              reset;
  logic              stall;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [63:0]       IF_ID;
  logic              if_valid;
  logic              halted;
  logic [31:0]       fetch_count;

  fetch_stage #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .IF_ID(IF_ID), .if_valid(if_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic [63:0] ifid;
    logic        vld;
    logic        hlt;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic chk_all(input string nm, input logic [63:0] e_ifid, input logic e_vld,
                         input logic e_hlt, input logic [31:0] e_cnt);
    chk({nm, " IF_ID"}, IF_ID, e_ifid);
    chk({nm, " if_valid"}, {63'h0, if_valid}, {63'h0, e_vld});
    chk({nm, " halted"}, {63'h0, halted}, {63'h0, e_hlt});
    chk({nm, " fetch_count"}, {32'h0, fetch_count}, {32'h0, e_cnt});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    step();
    imem_we = 1'b0;
  endtask

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                              input logic [31:0] pc, input logic [31:0] w,
                              input logic v, input logic h, input logic [31:0] c);
    vec_t r;
    r.stl = s; r.br = b; r.tgt = t; r.ifid = {pc, w};
    r.vld = v; r.hlt = h; r.cnt = c;
    return r;
  endfunction

  initial begin
    // stall, branch, target, expected pc, word, valid, halted, count
    vecs[0]  = mk(0, 0, 0,     0,  32'h00221800, 1, 0, 1);
    vecs[1]  = mk(0, 0, 0,     1,  32'h04221800, 1, 0, 2);
    vecs[2]  = mk(1, 0, 0,     1,  32'h04221800, 1, 0, 2);
    vecs[3]  = mk(1, 0, 0,     1,  32'h04221800, 1, 0, 2);
    vecs[4]  = mk(1, 0, 0,     1,  32'h04221800, 1, 0, 2);
    vecs[5]  = mk(0, 0, 0,     2,  32'h2C010005, 1, 0, 3);
    vecs[6]  = mk(0, 0, 0,     3,  32'h34000000, 1, 1, 4);
    vecs[7]  = mk(0, 0, 0,     3,  NOP,          0, 1, 4);
    vecs[8]  = mk(1, 0, 0,     3,  NOP,          0, 1, 4);
    vecs[9]  = mk(1, 1, 0,     3,  NOP,          0, 0, 4);
    vecs[10] = mk(0, 0, 0,     0,  32'h00221800, 1, 0, 5);
    vecs[11] = mk(0, 0, 0,     1,  32'h04221800, 1, 0, 6);
    vecs[12] = mk(0, 1, 32'h10, 2, NOP,          0, 0, 6);
    vecs[13] = mk(0, 0, 0,     16, 32'h0C0A0B0C, 1, 0, 7);
    vecs[14] = mk(0, 0, 0,     17, 32'h10000001, 1, 0, 8);
    vecs[15] = mk(0, 1, 5,     18, NOP,          0, 0, 8);
    vecs[16] = mk(1, 1, 32'h10, 5, NOP,          0, 0, 8);
    vecs[17] = mk(0, 0, 0,     16, 32'h0C0A0B0C, 1, 0, 9);
    vecs[18] = mk(0, 0, 0,     17, 32'h10000001, 1, 0, 10);
    vecs[19] = mk(0, 0, 0,     18, 32'h34000000, 1, 1, 11);
    vecs[20] = mk(0, 0, 0,     18, NOP,          0, 1, 11);

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;

    // Program loaded while reset is held.
    load(8'd0,  32'h00221800);
    load(8'd1,  32'h04221800);
    load(8'd2,  32'h2C010005);
    load(8'd3,  32'h34000000);
    load(8'd4,  32'h08421000);
    load(8'd5,  32'h0C000005);
    load(8'd16, 32'h0C0A0B0C);
    load(8'd17, 32'h10000001);
    load(8'd18, 32'h34000000);
    chk_all("reset", {32'h0, NOP}, 1'b0, 1'b0, 32'd0);

    reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      stall = vecs[i].stl;
      branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt;
      step();
      chk_all($sformatf("v%0d", i), vecs[i].ifid, vecs[i].vld, vecs[i].hlt, vecs[i].cnt);
    end
    stall = 1'b0; branch_taken = 1'b0;

    // Leave HALTED, run to pc=5, then reset mid-run.
    branch_taken = 1'b1; branch_target = 32'd4;
    step();
    branch_taken = 1'b0;
    chk_all("unhalt", {32'd18, NOP}, 1'b0, 1'b0, 32'd11);
    step();
    chk_all("pc4", {32'd4, 32'h08421000}, 1'b1, 1'b0, 32'd12);
    reset = 1'b1;
    step();
    chk_all("midreset", {32'h0, NOP}, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;

    // Same-edge write to the index being fetched returns the old word.
    imem_we = 1'b1; imem_waddr = 8'd0; imem_wdata = 32'hAAAAAAAA;
    step();
    imem_we = 1'b0;
    chk_all("rdold", {32'd0, 32'h00221800}, 1'b1, 1'b0, 32'd1);
    branch_taken = 1'b1; branch_target = 32'd0;
    step();
    branch_taken = 1'b0;
    chk_all("brback", {32'd1, NOP}, 1'b0, 1'b0, 32'd1);
    step();
    chk_all("rdnew", {32'd0, 32'hAAAAAAAA}, 1'b1, 1'b0, 32'd2);

    // PC wrap: 0xFFFFFFFF aliases imem[255], then wraps to 0.
    load(8'd255, 32'h14000000);
    branch_taken = 1'b1; branch_target = 32'hFFFFFFFF;
    step();
    branch_taken = 1'b0;
    step();
    chk_all("wraphi", {32'hFFFFFFFF, 32'h14000000}, 1'b1, 1'b0, 32'd4);
    step();
    chk_all("wraplo", {32'h0, 32'hAAAAAAAA}, 1'b1, 1'b0, 32'd5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
